// File: rtl/keydec_pkg.sv
// Shared constants and types for the PS/2 paddle key decoder.
// Optional feature macro: KEYDEC_PREFIX_TIMEOUT_EN (prefix-pending timeout).
package keydec_pkg;

    localparam int unsigned PADDLE_MAX_DFLT  = 400;
    localparam int unsigned PADDLE_INIT_DFLT = 200;
    localparam int unsigned STEP_DFLT        = 4;
    localparam int unsigned TICK_DIV_DFLT    = 1666667;
    localparam int unsigned TIMEOUT_CYC_DFLT = 2000000;

    localparam int unsigned Y_W   = 10;
    localparam int unsigned KEY_W = 5;
    localparam int unsigned IDX_W = 3;

    // Scan codes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    // key_state bit positions: {space, r_down, r_up, l_down, l_up}
    localparam int unsigned KEY_L_UP   = 0;
    localparam int unsigned KEY_L_DOWN = 1;
    localparam int unsigned KEY_R_UP   = 2;
    localparam int unsigned KEY_R_DOWN = 3;
    localparam int unsigned KEY_SPACE  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / key-and-paddle-out bundle between the PS/2 receiver side and the decoder.
interface ps2_key_decoder_if;
    import keydec_pkg::*;

    logic [7:0]       rx_data;
    logic             rx_done;
    logic [KEY_W-1:0] key_state;
    logic             serve_pulse;
    logic             move_tick;
    logic [Y_W-1:0]   paddle_l_y;
    logic [Y_W-1:0]   paddle_r_y;

    modport master (
        output rx_data, rx_done,
        input  key_state, serve_pulse, move_tick, paddle_l_y, paddle_r_y
    );

    modport slave (
        input  rx_data, rx_done,
        output key_state, serve_pulse, move_tick, paddle_l_y, paddle_r_y
    );
endinterface

// File: rtl/paddle_ctrl.sv
// One paddle Y register, stepped and clamped on each move tick.
module paddle_ctrl
    import keydec_pkg::*;
#(
    parameter int unsigned PADDLE_MAX  = PADDLE_MAX_DFLT,
    parameter int unsigned PADDLE_INIT = PADDLE_INIT_DFLT,
    parameter int unsigned STEP        = STEP_DFLT
) (
    input  logic           clk100MHz,
    input  logic           rst_n,
    input  logic           move_tick,
    input  logic           up,
    input  logic           down,
    output logic [Y_W-1:0] y
);
    localparam int unsigned SUM_W = Y_W + 1;

    logic [SUM_W-1:0] y_sum_c;

    // Downward sum one bit wider so it cannot wrap before the clamp
    assign y_sum_c = {1'b0, y} + SUM_W'(STEP);

    // Move up/down by STEP on each tick; opposing keys cancel
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            y <= Y_W'(PADDLE_INIT);
        end else if (move_tick) begin
            if (up && !down) begin
                y <= (y >= Y_W'(STEP)) ? y - Y_W'(STEP) : '0;
            end else if (down && !up) begin
                y <= (y_sum_c <= SUM_W'(PADDLE_MAX)) ? y_sum_c[Y_W-1:0] : Y_W'(PADDLE_MAX);
            end
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: held key states, serve pulse, frame tick, paddle positions.
// Optional feature macro: KEYDEC_PREFIX_TIMEOUT_EN drops a stale E0/F0 prefix after TIMEOUT_CYC idle cycles.
module ps2_key_decoder
    import keydec_pkg::*;
#(
    parameter int unsigned PADDLE_MAX  = PADDLE_MAX_DFLT,
    parameter int unsigned PADDLE_INIT = PADDLE_INIT_DFLT,
    parameter int unsigned STEP        = STEP_DFLT,
    parameter int unsigned TICK_DIV    = TICK_DIV_DFLT
`ifdef KEYDEC_PREFIX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
`endif
) (
    input  logic               clk100MHz,
    input  logic               rst_n,
    ps2_key_decoder_if.slave   bus
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic             s1, s2, s3;
    logic             byte_strobe_c;
    dec_state_t       state;
    logic [KEY_W-1:0] key_q;
    logic             serve_q;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick_q;
    logic             ext_c, brk_c, hit_c;
    logic [IDX_W-1:0] key_idx_c;
    logic             timeout_c;
    logic [Y_W-1:0]   l_y, r_y;

    // rx_done crosses domains: two-flop sync plus one flop for rising-edge detect
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.rx_done;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign byte_strobe_c = s2 & ~s3;

    // Map the incoming byte to a key bit, honouring the pending E0 prefix
    always_comb begin
        ext_c     = (state == ST_EXT) || (state == ST_EXT_BRK);
        brk_c     = (state == ST_BRK) || (state == ST_EXT_BRK);
        hit_c     = 1'b0;
        key_idx_c = '0;
        if (ext_c) begin
            if (bus.rx_data == SC_UP) begin
                hit_c     = 1'b1;
                key_idx_c = IDX_W'(KEY_R_UP);
            end else if (bus.rx_data == SC_DOWN) begin
                hit_c     = 1'b1;
                key_idx_c = IDX_W'(KEY_R_DOWN);
            end
        end else begin
            if (bus.rx_data == SC_W) begin
                hit_c     = 1'b1;
                key_idx_c = IDX_W'(KEY_L_UP);
            end else if (bus.rx_data == SC_S) begin
                hit_c     = 1'b1;
                key_idx_c = IDX_W'(KEY_L_DOWN);
            end else if (bus.rx_data == SC_SPACE) begin
                hit_c     = 1'b1;
                key_idx_c = IDX_W'(KEY_SPACE);
            end
        end
    end

`ifdef KEYDEC_PREFIX_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] prefix_tmr;

    assign timeout_c = (state != ST_IDLE) && (prefix_tmr == TMR_W'(TIMEOUT_CYC - 1));

    // Count idle cycles while a prefix is pending; any byte restarts the count
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            prefix_tmr <= '0;
        end else if (byte_strobe_c || state == ST_IDLE) begin
            prefix_tmr <= '0;
        end else begin
            prefix_tmr <= prefix_tmr + TMR_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Prefix FSM with key-state and serve-pulse updates on each received byte
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            key_q   <= '0;
            serve_q <= 1'b0;
        end else begin
            serve_q <= 1'b0;
            if (byte_strobe_c) begin
                case (bus.rx_data)
                    SC_EXT: state <= ST_EXT;
                    SC_BRK: begin
                        if (state == ST_IDLE) begin
                            state <= ST_BRK;
                        end else if (state == ST_EXT) begin
                            state <= ST_EXT_BRK;
                        end
                    end
                    SC_ERR0, SC_ERR1: begin
                        key_q <= '0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (hit_c) begin
                            key_q[key_idx_c] <= ~brk_c;
                            if (key_idx_c == IDX_W'(KEY_SPACE) && !brk_c && !key_q[KEY_SPACE]) begin
                                serve_q <= 1'b1;
                            end
                        end
                    end
                endcase
            end else if (timeout_c) begin
                state <= ST_IDLE;
            end
        end
    end

    // Frame-rate divider; move_tick is registered so it lines up with the last count
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            tick_q   <= (tick_cnt == CNT_W'(TICK_DIV - 2));
            tick_cnt <= (tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    paddle_ctrl #(
        .PADDLE_MAX  (PADDLE_MAX),
        .PADDLE_INIT (PADDLE_INIT),
        .STEP        (STEP)
    ) u_paddle_l (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .move_tick (tick_q),
        .up        (key_q[KEY_L_UP]),
        .down      (key_q[KEY_L_DOWN]),
        .y         (l_y)
    );

    paddle_ctrl #(
        .PADDLE_MAX  (PADDLE_MAX),
        .PADDLE_INIT (PADDLE_INIT),
        .STEP        (STEP)
    ) u_paddle_r (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .move_tick (tick_q),
        .up        (key_q[KEY_R_UP]),
        .down      (key_q[KEY_R_DOWN]),
        .y         (r_y)
    );

    assign bus.key_state   = key_q;
    assign bus.serve_pulse = serve_q;
    assign bus.move_tick   = tick_q;
    assign bus.paddle_l_y  = l_y;
    assign bus.paddle_r_y  = r_y;
endmodule
